// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS memory subsystem.
// Provides bus widths, the arbiter FSM state and owner enums, and the
// grant-vector bit positions shared by the arbiter and its winner-select logic.
package mips_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Width of the latency and starvation counters (legal limits are 1..15).
  localparam int CNT_W = 4;

  // Bit positions in the winner-select grant vector.
  localparam int GNT_IF = 0;
  localparam int GNT_D  = 1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF   = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mips_arb_pick.sv
// mips_arb_pick: combinational winner select for the memory arbiter.
// Data requests beat fetches, except when a fetch has been passed over
// STARVE_MAX times in a row, in which case the fetch is forced through.
// Ports:
//   if_req, d_req   : pending requests
//   starve_cnt      : consecutive data wins while a fetch was waiting
//   grant           : one-hot winner (GNT_IF / GNT_D), zero if no request
//   starve_next     : counter value to load if this grant is taken
module mips_arb_pick
  import mips_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             if_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] starve_next
);

  localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

  logic if_forced;
  logic d_win;
  logic if_win;

  assign if_forced = if_req && (starve_cnt == STARVE_TOP);
  assign d_win     = d_req && !if_forced;
  assign if_win    = if_req && !d_win;

  always_comb begin
    grant         = '0;
    grant[GNT_IF] = if_win;
    grant[GNT_D]  = d_win;

    starve_next = starve_cnt;
    if (if_win) begin
      starve_next = '0;
    end else if (d_win && if_req && (starve_cnt != STARVE_TOP)) begin
      starve_next = starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: single-port memory arbiter between the fetch (IF) and
// load/store (D) ports of the MIPS pipeline.
// One transaction at a time: the accept cycle drives mem_* combinationally
// with mem_en=1, the FSM then waits MEM_LAT cycles, captures mem_rdata into
// the owner's rdata register, and pulses the owner's rvalid the cycle after.
// Ports:
//   clk, reset (async, active-low)
//   if_req/if_addr -> if_ready, if_rvalid, if_rdata
//   d_req/d_we/d_addr/d_wdata/d_be -> d_ready, d_rvalid, d_rdata
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be -> memory, mem_rdata <- memory
//   busy : high while waiting on memory
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ready,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT);

  arb_state_t       state_reg, state_next;
  arb_owner_t       owner_reg, owner_next;
  logic [CNT_W-1:0] lat_cnt_reg, lat_cnt_next;
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             store_reg, store_next;
  logic [DATA_W-1:0] if_rdata_reg, d_rdata_reg;
  logic             if_rvalid_reg, d_rvalid_reg;

  logic [1:0]       grant;
  logic [CNT_W-1:0] starve_pick;
  logic             accept_if, accept_d, capture;

  mips_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt_reg),
    .grant      (grant),
    .starve_next(starve_pick)
  );

  // Gating with reset keeps ready/mem_* at 0 while reset is held, since
  // these paths are combinational from the request inputs.
  assign accept_if = reset && (state_reg == ARB_IDLE) && grant[GNT_IF];
  assign accept_d  = reset && (state_reg == ARB_IDLE) && grant[GNT_D];
  assign capture   = (state_reg == ARB_WAIT) && (lat_cnt_reg == LAT_LAST);

  assign if_ready  = accept_if;
  assign d_ready   = accept_d;
  assign mem_en    = accept_if || accept_d;
  assign mem_we    = accept_d && d_we;
  assign mem_addr  = accept_d ? d_addr : (accept_if ? if_addr : '0);
  assign mem_wdata = accept_d ? d_wdata : '0;
  assign mem_be    = accept_d ? d_be : '0;

  assign busy      = (state_reg == ARB_WAIT);
  assign if_rvalid = if_rvalid_reg;
  assign d_rvalid  = d_rvalid_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    lat_cnt_next    = lat_cnt_reg;
    starve_cnt_next = starve_cnt_reg;
    store_next      = store_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (accept_if || accept_d) begin
          state_next      = ARB_WAIT;
          owner_next      = accept_d ? OWN_DATA : OWN_IF;
          store_next      = accept_d && d_we;
          lat_cnt_next    = CNT_W'(1);
          starve_cnt_next = starve_pick;
        end
      end
      ARB_WAIT: begin
        if (capture) begin
          state_next   = ARB_IDLE;
          lat_cnt_next = '0;
        end else begin
          lat_cnt_next = lat_cnt_reg + 1'b1;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ARB_IDLE;
      owner_reg      <= OWN_IF;
      lat_cnt_reg    <= '0;
      starve_cnt_reg <= '0;
      store_reg      <= 1'b0;
      if_rdata_reg   <= '0;
      d_rdata_reg    <= '0;
      if_rvalid_reg  <= 1'b0;
      d_rvalid_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      lat_cnt_reg    <= lat_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
      store_reg      <= store_next;
      if_rvalid_reg  <= capture && (owner_reg == OWN_IF);
      d_rvalid_reg   <= capture && (owner_reg == OWN_DATA);
      if (capture && (owner_reg == OWN_IF)) begin
        if_rdata_reg <= mem_rdata;
      end
      if (capture && (owner_reg == OWN_DATA)) begin
        d_rdata_reg <= store_reg ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed self-checking bench for mips_mem_arbiter
// with MEM_LAT=2 and STARVE_MAX=4.
module tb_mips_mem_arbiter;
  import mips_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                if_req;
  logic [ADDR_W-1:0]   if_addr;
  logic                if_ready, if_rvalid;
  logic [DATA_W-1:0]   if_rdata;
  logic                d_req, d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic                d_ready, d_rvalid;
  logic [DATA_W-1:0]   d_rdata;
  logic                mem_en, mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0]   mem_rdata;
  logic                busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mips_mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b1;
    d_addr = 32'h20; d_wdata = 32'h1234_5678; d_be = 4'hF; mem_rdata = 32'hAAAA_5555;
    step; step; #1;
    total_cnt++;
    if ({if_ready, d_ready, if_rvalid, d_rvalid, mem_en, mem_we, busy} !== 7'b0)
      $display("FAIL reset_flags: got %b required 0000000",
               {if_ready, d_ready, if_rvalid, d_rvalid, mem_en, mem_we, busy});
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr, mem_wdata, mem_be, if_rdata, d_rdata} !== '0)
      $display("FAIL reset_data: addr %h wdata %h be %h if_rdata %h d_rdata %h required all 0",
               mem_addr, mem_wdata, mem_be, if_rdata, d_rdata);
    else pass_cnt++;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    step; reset = 1'b1; step;
    $display("test_reset done");
  endtask

  task automatic test_single_fetch;
    if_req = 1'b1; if_addr = 32'h0000_0004; #1;
    total_cnt++;
    if ({if_ready, d_ready, mem_en, mem_we, busy} !== 5'b10100 || mem_addr !== 32'h4)
      $display("FAIL fetch_accept: rdy/drdy/en/we/busy %b addr %h required 10100 addr 00000004",
               {if_ready, d_ready, mem_en, mem_we, busy}, mem_addr);
    else pass_cnt++;
    step; if_req = 1'b0; #1;                        // T+1
    total_cnt++;
    if ({mem_en, busy, if_ready} !== 3'b010)
      $display("FAIL fetch_t1: en/busy/rdy %b required 010", {mem_en, busy, if_ready});
    else pass_cnt++;
    step; mem_rdata = 32'h2008_0005; #1;            // T+2
    total_cnt++;
    if ({mem_en, busy, if_rvalid} !== 3'b010)
      $display("FAIL fetch_t2: en/busy/rvalid %b required 010", {mem_en, busy, if_rvalid});
    else pass_cnt++;
    step; mem_rdata = 32'h0;                        // T+3
    total_cnt++;
    if ({if_rvalid, d_rvalid, busy} !== 3'b100 || if_rdata !== 32'h2008_0005)
      $display("FAIL fetch_rvalid: rv/drv/busy %b rdata %h required 100 rdata 20080005",
               {if_rvalid, d_rvalid, busy}, if_rdata);
    else pass_cnt++;
    step;                                           // T+4
    total_cnt++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h2008_0005)
      $display("FAIL fetch_hold: rvalid %b rdata %h required 0 rdata 20080005", if_rvalid, if_rdata);
    else pass_cnt++;
    $display("test_single_fetch done");
  endtask

  task automatic test_simultaneous;
    if_req = 1'b1; if_addr = 32'h0000_0008; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h0000_0100; d_be = 4'hF; #1;        // T
    total_cnt++;
    if ({d_ready, if_ready, mem_en, mem_we} !== 4'b1010 || mem_addr !== 32'h100)
      $display("FAIL simul_accept: drdy/irdy/en/we %b addr %h required 1010 addr 00000100",
               {d_ready, if_ready, mem_en, mem_we}, mem_addr);
    else pass_cnt++;
    step; d_req = 1'b0; #1;                         // T+1
    total_cnt++;
    if ({if_ready, mem_en} !== 2'b00)
      $display("FAIL simul_if_blocked: irdy/en %b required 00", {if_ready, mem_en});
    else pass_cnt++;
    step; mem_rdata = 32'h1111_2222;                // T+2
    step; mem_rdata = 32'h0;                        // T+3
    total_cnt++;
    if ({d_rvalid, if_rvalid, if_ready, mem_en} !== 4'b1011 || d_rdata !== 32'h1111_2222
        || mem_addr !== 32'h8)
      $display("FAIL simul_t3: drv/irv/irdy/en %b drdata %h addr %h required 1011 11112222 00000008",
               {d_rvalid, if_rvalid, if_ready, mem_en}, d_rdata, mem_addr);
    else pass_cnt++;
    step; if_req = 1'b0;                            // T+4
    step; mem_rdata = 32'h3333_4444;                // T+5
    step; mem_rdata = 32'h0;                        // T+6
    total_cnt++;
    if ({if_rvalid, d_rvalid} !== 2'b10 || if_rdata !== 32'h3333_4444)
      $display("FAIL simul_if_rvalid: irv/drv %b rdata %h required 10 33334444",
               {if_rvalid, d_rvalid}, if_rdata);
    else pass_cnt++;
    step;
    $display("test_simultaneous done");
  endtask

  task automatic test_store;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    mem_rdata = 32'hFFFF_FFFF; #1;                  // T
    total_cnt++;
    if ({d_ready, mem_en, mem_we} !== 3'b111 || mem_be !== 4'b0011
        || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h40)
      $display("FAIL store_cmd: rdy/en/we %b be %b wdata %h addr %h required 111 0011 deadbeef 00000040",
               {d_ready, mem_en, mem_we}, mem_be, mem_wdata, mem_addr);
    else pass_cnt++;
    step; d_req = 1'b0; d_we = 1'b0;
    step; step;                                     // T+3
    total_cnt++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h0)
      $display("FAIL store_resp: rvalid %b rdata %h required 1 00000000", d_rvalid, d_rdata);
    else pass_cnt++;
    mem_rdata = 32'h0;
    step;
    $display("test_store done");
  endtask

  task automatic test_starvation;
    string expected = "DDDDID";
    int n;
    byte got;
    if_req = 1'b1; if_addr = 32'h0000_0200; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h0000_0300; #1;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      while (!(if_ready || d_ready) && n < 8) begin
        step; n++;
      end
      got = d_ready ? "D" : (if_ready ? "I" : "-");
      total_cnt++;
      if (got !== expected[g] || n != ((g == 0) ? 0 : 2))
        $display("FAIL starve_grant%0d: winner %s after %0d waits required %s after %0d waits",
                 g, got, n, expected[g], (g == 0) ? 0 : 2);
      else pass_cnt++;
      step;
    end
    if_req = 1'b0; d_req = 1'b0;
    step; step; step;
    $display("test_starvation done");
  endtask

  task automatic test_reset_mid;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500; #1;   // T
    total_cnt++;
    if (d_ready !== 1'b1)
      $display("FAIL rmid_accept: d_ready %b required 1", d_ready);
    else pass_cnt++;
    step; d_req = 1'b0; reset = 1'b0; #1;           // T+1, reset asynchronously
    total_cnt++;
    if ({busy, mem_en, d_rvalid, if_rvalid} !== 4'b0 || if_rdata !== '0 || d_rdata !== '0)
      $display("FAIL rmid_clear: busy/en/drv/irv %b if_rdata %h d_rdata %h required 0000 0 0",
               {busy, mem_en, d_rvalid, if_rvalid}, if_rdata, d_rdata);
    else pass_cnt++;
    step; mem_rdata = 32'h7777_7777; reset = 1'b1; // T+2
    step;                                           // T+3
    total_cnt++;
    if ({d_rvalid, busy} !== 2'b00)
      $display("FAIL rmid_no_rvalid: drv/busy %b required 00", {d_rvalid, busy});
    else pass_cnt++;
    mem_rdata = 32'h0;
    if_req = 1'b1; if_addr = 32'h0000_0600; #1;
    total_cnt++;
    if ({if_ready, mem_en} !== 2'b11 || mem_addr !== 32'h600)
      $display("FAIL rmid_restart: irdy/en %b addr %h required 11 00000600", {if_ready, mem_en}, mem_addr);
    else pass_cnt++;
    step; if_req = 1'b0;
    step; step; step;
    $display("test_reset_mid done");
  endtask

  task automatic test_withdrawn;
    int bad = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0700; #1;  // T
    step; d_req = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0800; #1;   // T+1
    if (if_ready !== 1'b0 || mem_en !== 1'b0) bad++;
    step; if_req = 1'b0; #1;                        // T+2
    if (if_ready !== 1'b0 || mem_en !== 1'b0) bad++;
    for (int c = 0; c < 4; c++) begin               // T+3 ..
      step;
      if (if_ready !== 1'b0 || mem_en !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0)
      $display("FAIL withdrawn: %0d cycles with if_ready/mem_en set required 0", bad);
    else pass_cnt++;
    $display("test_withdrawn done");
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store();
    test_starvation();
    test_reset_mid();
    test_withdrawn();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Single-port memory arbiter for the MIPS CPU: shares one unified instruction/data memory between the fetch stage (IF port) and the load/store stage (D port). It sits between the CPU pipeline and the memory model. It serialises accesses, applies data-over-fetch priority with a starvation guard, and returns read data with a fixed, parameterised latency.

## Interface
- `ADDR_W`, 32, address width (byte address)
- `DATA_W`, 32, data width
- `MEM_LAT`, 2, cycles from memory issue until `mem_rdata` is valid; legal range 1..15
- `STARVE_MAX`, 4, consecutive data grants made while `if_req` is pending before IF is forced to win; legal range 1..15

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low; `reset`=0 clears all state immediately
- `if_req` in 1: fetch request, held until `if_ready`
- `if_addr` in ADDR_W: fetch address
- `if_ready` out 1: one-cycle accept pulse for the fetch request
- `if_rvalid` out 1: one-cycle fetch data valid
- `if_rdata` out DATA_W: fetched instruction
- `d_req` in 1: data request, held until `d_ready`
- `d_we` in 1: 1 = store, 0 = load
- `d_addr` in ADDR_W, `d_wdata` in DATA_W, `d_be` in DATA_W/8: data payload
- `d_ready` out 1: one-cycle accept pulse for the data request
- `d_rvalid` out 1: one-cycle completion pulse for loads and stores
- `d_rdata` out DATA_W: load data; 0 for stores
- `mem_en`, `mem_we` out 1; `mem_addr` out ADDR_W; `mem_wdata` out DATA_W; `mem_be` out DATA_W/8: memory command
- `mem_rdata` in DATA_W: memory read data
- `busy` out 1: high while in ARB_WAIT

## Operation
- States: ARB_IDLE, ARB_WAIT.
- **ARB_IDLE, no request:** all command outputs are 0.
- **ARB_IDLE, request pending:** pick a winner, assert its `*_ready` and drive `mem_*` combinationally from its payload, with `mem_en`=1 for exactly that cycle. Then go to ARB_WAIT, latch the owner, and set the latency counter to 1.
- **Priority:**
  - D wins when `d_req`=1, unless `if_req`=1 and `starve_cnt`==STARVE_MAX.
  - IF wins otherwise when `if_req`=1.
- **`starve_cnt` update:**
  - +1 when D wins while `if_req`=1 (saturates at STARVE_MAX).
  - Cleared when IF wins.
  - Unchanged otherwise.
- **ARB_WAIT:**
  - The counter increments each cycle.
  - In the cycle where counter==MEM_LAT, capture `mem_rdata` into the owner's rdata register (stores capture 0), then go to ARB_IDLE.
  - `mem_en` stays 0 throughout.
- **Response:** in the cycle after capture, the owner's `*_rvalid`=1 for one cycle with registered rdata.
  - The arbiter is in ARB_IDLE in that cycle and may accept a new request in the same cycle.
- **Rdata hold:** the rdata registers hold their value until the next capture for that port.
- **Payload stability:** a request dropped before its accept pulse is never issued.
- **Payload sampling:** payload is sampled only in the accept cycle.
- **Reset (`reset`=0, any state, including mid-transaction):**
  - State returns to ARB_IDLE; the in-flight transaction is discarded and no `rvalid` is produced for it.
  - `starve_cnt`=0, counter=0.
  - Reset values: `if_ready`=0, `d_ready`=0, `if_rvalid`=0, `d_rvalid`=0, `if_rdata`=0, `d_rdata`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0, `busy`=0.

## Timing
- Accept at cycle T.
  - `mem_en` is high only at T.
  - `busy` is high T+1..T+MEM_LAT.
  - `mem_rdata` is sampled at the end of T+MEM_LAT.
  - `*_rvalid` is high at T+MEM_LAT+1.
- Accept-to-rvalid latency is MEM_LAT+1 cycles.
- Best-case throughput is one accept every MEM_LAT+1 cycles; the next accept can coincide with the previous `rvalid`.
- `*_ready` is combinational from `*_req`, state and `starve_cnt`.
- Every other output except `mem_*` is registered; `mem_*` is combinational in the accept cycle only.
- Never both `if_ready` and `d_ready` high; never both `rvalid` high.

## Structure
- Shared package `mips_pkg`:
  - `ADDR_W`, `DATA_W` constants
  - `arb_state_t` {ARB_IDLE, ARB_WAIT}
  - `arb_owner_t` {OWN_IF, OWN_DATA}
- One natural sub-module, `mips_arb_pick`: combinational winner select.
  - Inputs: `if_req`, `d_req`, `starve_cnt`.
  - Outputs: grant vector and next `starve_cnt`.
  - Keeps the FSM file free of priority logic.

## Test plan
All scenarios use MEM_LAT=2 and STARVE_MAX=4.
- **Single fetch:** `if_req`=1, `if_addr`=0x0000_0004, `mem_rdata`=0x2008_0005 at T+2 -> `if_ready` at T, `mem_en` only at T, `if_rvalid`=1 with `if_rdata`=0x2008_0005 at T+3, `busy` high T+1..T+2.
- **Simultaneous requests:** `if_req`=`d_req`=1, D is a load from 0x0000_0100 -> D accepted first (`d_ready` at T, `d_rvalid` at T+3), IF accepted at T+3, `if_rvalid` at T+6.
- **Store:** `d_we`=1, `d_addr`=0x40, `d_wdata`=0xDEAD_BEEF, `d_be`=4'b0011 -> `mem_we`=1, `mem_be`=0011, `mem_wdata`=0xDEAD_BEEF at T, `d_rvalid` at T+3 with `d_rdata`=0.
- **Starvation:** `if_req` and `d_req` held high continuously -> four D grants, then the fifth grant goes to IF, then `starve_cnt` reads 0 and D wins again.
- **Reset mid-transaction:** `reset`=0 at T+1 after a D accept -> all outputs 0 immediately, no `d_rvalid` at T+3. After `reset`=1, a new `if_req` is accepted the next edge.
- **Request withdrawn while busy:** `if_req` pulses only during ARB_WAIT of a D access -> never accepted, `mem_en` is never asserted for it.
